// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: owns the read pointer, derives empty from the
// synchronised Gray write pointer and drains fifo_mem into a 2-entry valid/ready output buffer.
module fifo_rd_ctrl #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [PTR_WIDTH:0]    g_wptr_sync,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  r_en,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    fill_level,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    logic [PTR_WIDTH:0]    b_rptr_q, b_rptr_d;
    logic [PTR_WIDTH:0]    g_rptr_q, g_rptr_d;
    logic [PTR_WIDTH:0]    wptr_bin;
    logic                  empty_q, empty_d;
    logic                  pend_q;
    logic [1:0]            occ_q, occ_d;
    logic [1:0]            slot;
    logic [2:0]            committed;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  pop;
    logic                  rd_en;

    // Stream handshake: a word transfers on any rclk edge where dout_valid and dout_ready
    // are both high; dout_valid never drops and dout never changes while waiting for ready.
    assign pop = (occ_q != 2'd0) && dout_ready;

    // Words already owned by the buffer (stored or in flight) after this cycle's pop.
    assign committed = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    assign rd_en     = !empty_q && !rrst && (committed <= 3'd1);

    always_comb begin
        b_rptr_d = b_rptr_q + {{PTR_WIDTH{1'b0}}, rd_en};
        g_rptr_d = b_rptr_d ^ (b_rptr_d >> 1);
        empty_d  = (g_rptr_d == g_wptr_sync);
    end

    always_comb begin
        wptr_bin = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            wptr_bin[i] = ^(g_wptr_sync >> i);
        end
    end

    // A returning word lands in the first free slot after this cycle's pop.
    always_comb begin
        occ_d  = occ_q + {1'b0, pend_q} - {1'b0, pop};
        slot   = occ_q - {1'b0, pop};
        head_d = head_q;
        skid_d = skid_q;
        if (pop && (occ_q == 2'd2)) begin
            head_d = skid_q;
        end
        if (pend_q) begin
            if (slot == 2'd0) begin
                head_d = mem_rdata;
            end else begin
                skid_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            b_rptr_q <= '0;
            g_rptr_q <= '0;
            empty_q  <= 1'b1;
            pend_q   <= 1'b0;
            occ_q    <= 2'd0;
            head_q   <= '0;
            skid_q   <= '0;
        end else begin
            b_rptr_q <= b_rptr_d;
            g_rptr_q <= g_rptr_d;
            empty_q  <= empty_d;
            pend_q   <= rd_en;
            occ_q    <= occ_d;
            head_q   <= head_d;
            skid_q   <= skid_d;
        end
    end

    assign r_en       = rd_en;
    assign b_rptr     = b_rptr_q;
    assign g_rptr     = g_rptr_q;
    assign empty      = empty_q;
    assign fill_level = wptr_bin - b_rptr_q;
    assign dout       = head_q;
    assign dout_valid = (occ_q != 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a memory/writer model drives the DUT, and a queue-based model of
// read counts and buffered words is compared against the outputs every cycle.
module tb_fifo_rd_ctrl;
    localparam int PW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          rclk = 1'b0;
    logic          rrst;
    logic [PW:0]   g_wptr_sync;
    logic [DW-1:0] mem_rdata;
    logic          r_en;
    logic [PW:0]   b_rptr;
    logic [PW:0]   g_rptr;
    logic          empty;
    logic [PW:0]   fill_level;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    always #5 rclk = ~rclk;

    fifo_rd_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
        .rclk(rclk), .rrst(rrst), .g_wptr_sync(g_wptr_sync), .mem_rdata(mem_rdata),
        .r_en(r_en), .b_rptr(b_rptr), .g_rptr(g_rptr), .empty(empty),
        .fill_level(fill_level), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: absolute write/read counts since reset, words written, words buffered.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] hist[$];
    logic [DW-1:0] exp_q[$];
    int  wcount = 0, rcount = 0, rst_wcount = 0;
    bit  m_empty = 1, m_pend = 0;
    int  m_pend_idx = 0;
    bit  exp_pop = 0, exp_ren = 0, cur_rst = 0;
    bit  issued = 0;
    int  issued_addr = 0;
    bit  checks_on = 0;
    bit  force_valid = 0;
    logic [DW-1:0] force_data = '0;
    logic [PW:0] prev_b = '0, prev_g = '0;
    bit  saw_b_wrap = 0, saw_g_wrap = 0;

    function automatic logic [PW:0] gray(input int v);
        logic [PW:0] b;
        b = v[PW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then compare the settled outputs with the model.
    task automatic drive(input bit rst, input int nwr, input bit rdy);
        logic [DW-1:0] d;
        rrst = rst;
        dout_ready = rdy;
        cur_rst = rst;
        if (rst) begin
            wcount = rst_wcount;
            hist.delete();
        end else begin
            for (int i = 0; i < nwr; i++) begin
                if (wcount - rcount < DEPTH) begin
                    d = force_valid ? force_data : DW'($urandom_range(0, 255));
                    force_valid = 0;
                    mem[wcount % DEPTH] = d;
                    hist.push_back(d);
                    wcount++;
                end
            end
        end
        g_wptr_sync = gray(wcount);
        #1;
        exp_pop = (exp_q.size() != 0) && rdy;
        exp_ren = !m_empty && !rst && ((exp_q.size() + int'(m_pend) - int'(exp_pop)) <= 1);
        if (checks_on) begin
            check("r_en", r_en, exp_ren);
            check("b_rptr", b_rptr, rcount % 16);
            check("g_rptr", g_rptr, gray(rcount));
            check("empty", empty, m_empty);
            check("dout_valid", dout_valid, exp_q.size() != 0);
            check("fill_level", fill_level, (wcount - rcount) & 15);
            if (exp_q.size() != 0) check("dout", dout, exp_q[0]);
            if (prev_b == 4'd15 && b_rptr == 4'd0) saw_b_wrap = 1;
            if (prev_g == 4'b1000 && g_rptr == 4'b0000) saw_g_wrap = 1;
            prev_b = b_rptr;
            prev_g = g_rptr;
        end
    endtask

    // Advance the model across the rising edge and present fifo_mem read data.
    task automatic clk_step();
        @(posedge rclk);
        if (cur_rst) begin
            rcount = 0;
            m_empty = 1;
            m_pend = 0;
            exp_q.delete();
            issued = 0;
        end else begin
            if (exp_pop) void'(exp_q.pop_front());
            if (m_pend) exp_q.push_back(hist[m_pend_idx]);
            m_pend = exp_ren;
            m_pend_idx = rcount;
            issued = exp_ren;
            issued_addr = rcount % DEPTH;
            if (exp_ren) rcount++;
            m_empty = (rcount == wcount);
        end
        checks_on = 1;
        @(negedge rclk);
        if (cur_rst) mem_rdata = 8'hEE;
        else if (issued) mem_rdata = mem[issued_addr];
        else mem_rdata = DW'($urandom_range(0, 255));
    endtask

    initial begin
        int pulses;
        int budget;
        int target;
        rrst = 1'b1;
        dout_ready = 1'b0;
        g_wptr_sync = '0;
        mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset hold with a non-zero write pointer on the input.
        rst_wcount = 4;
        drive(1, 0, 0);
        clk_step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            check("t1_g_wptr_in", g_wptr_sync, 4'b0110);
            check("t1_r_en", r_en, 0);
            check("t1_empty", empty, 1);
            check("t1_dout_valid", dout_valid, 0);
            check("t1_b_rptr", b_rptr, 0);
            check("t1_g_rptr", g_rptr, 0);
            check("t1_dout", dout, 0);
            check("t1_fill", fill_level, 4);
            clk_step();
        end
        rst_wcount = 0;
        drive(1, 0, 0);
        clk_step();

        // Single word.
        force_data = 8'hA5;
        force_valid = 1;
        drive(0, 1, 1);
        check("t2_empty_before", empty, 1);
        check("t2_no_read_yet", r_en, 0);
        clk_step();
        drive(0, 0, 1);
        check("t2_empty_fell", empty, 0);
        check("t2_r_en", r_en, 1);
        check("t2_b_rptr0", b_rptr, 0);
        clk_step();
        drive(0, 0, 1);
        check("t2_r_en_once", r_en, 0);
        clk_step();
        drive(0, 0, 1);
        check("t2_valid", dout_valid, 1);
        check("t2_dout", dout, 8'hA5);
        clk_step();
        drive(0, 0, 1);
        check("t2_b_rptr1", b_rptr, 1);
        check("t2_g_rptr1", g_rptr, 1);
        check("t2_empty_again", empty, 1);
        clk_step();

        // Back-pressure: five words pending, consumer stalled.
        drive(1, 0, 0);
        clk_step();
        drive(0, 5, 0);
        clk_step();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0);
            pulses += int'(r_en);
            clk_step();
        end
        check("t3_pulses", pulses, 2);
        drive(0, 0, 0);
        check("t3_r_en_idle", r_en, 0);
        check("t3_valid", dout_valid, 1);
        check("t3_head", dout, hist[0]);
        check("t3_fill", fill_level, 3);
        clk_step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1);
            check("t3_stream_valid", dout_valid, 1);
            check("t3_stream_word", dout, hist[i]);
            clk_step();
        end

        // Twenty rounds of DEPTH writes with random back-pressure, across pointer wraps.
        drive(1, 0, 0);
        clk_step();
        saw_b_wrap = 0;
        saw_g_wrap = 0;
        for (int r = 0; r < 20; r++) begin
            budget = 0;
            target = wcount + DEPTH;
            while ((wcount < target || rcount < wcount || exp_q.size() != 0 || m_pend)
                   && budget < 200) begin
                drive(0, (wcount < target) ? 1 : 0, $urandom_range(0, 3) != 0);
                clk_step();
                budget++;
            end
            check("t4_round_timeout", budget < 200, 1);
        end
        check("t4_b_wrap", saw_b_wrap, 1);
        check("t4_g_wrap", saw_g_wrap, 1);

        // Last-read race: a new write arrives in the cycle the last word is read.
        drive(0, 1, 1);
        clk_step();
        drive(0, 1, 1);
        check("t5_r_en_last", r_en, 1);
        check("t5_fill", fill_level, 2);
        clk_step();
        drive(0, 0, 1);
        check("t5_empty_held", empty, 0);
        check("t5_r_en_next", r_en, 1);
        clk_step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1);
            clk_step();
        end

        // Reset while one word is buffered and another is in flight.
        drive(0, 3, 0);
        clk_step();
        budget = 0;
        while (!(m_pend && exp_q.size() == 1) && budget < 20) begin
            drive(0, 0, 0);
            clk_step();
            budget++;
        end
        check("t6_setup_timeout", budget < 20, 1);
        drive(1, 0, 0);
        clk_step();
        drive(0, 0, 1);
        check("t6_valid", dout_valid, 0);
        check("t6_b_rptr", b_rptr, 0);
        check("t6_empty", empty, 1);
        clk_step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1);
            check("t6_no_discard_valid", dout_valid, 0);
            check("t6_no_discard_dout", dout, 0);
            clk_step();
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 2), $urandom_range(0, 3) != 0);
            clk_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
